// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative HI/LO multiply/divide unit for the EX stage
//
// Ports:
//   Clk       - clock, all state changes on the rising edge
//   Rst       - synchronous active-high reset
//   Start     - operation request (taken only in IDLE without Flush)
//   Op[2:0]   - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   A[31:0]   - Rs operand (multiplicand / dividend / move source)
//   B[31:0]   - Rt operand (multiplier / divisor)
//   Flush     - abort an in-flight operation
//   Busy      - stall request, high while in RUN or FIX
//   Done      - one-cycle completion pulse
//   DivByZero - one-cycle pulse with Done when a divide had B = 0
//   Hi, Lo    - architectural HI/LO registers
module ex_muldiv_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [63:0] acc;       // multiply: {partial product, multiplier}; divide: {remainder, quotient}
  logic [31:0] opnd;      // multiplicand or divisor magnitude
  logic        is_div;
  logic        neg_res;   // negate product / quotient in FIX
  logic        neg_rem;   // negate remainder in FIX (dividend was negative)
  logic        dbz_pend;

  // Operands are reduced to magnitudes so the datapath is purely unsigned.
  logic        signed_op;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign signed_op = (Op == OP_MULT) || (Op == OP_DIV);
  assign a_neg     = signed_op & A[31];
  assign b_neg     = signed_op & B[31];
  assign a_mag     = a_neg ? (32'd0 - A) : A;
  assign b_mag     = b_neg ? (32'd0 - B) : B;

  // One shift-add step: the carry out of the add shifts into the top bit.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
  assign mul_next = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};

  // One restoring step: shifted remainder is 33 bits wide, borrow means restore.
  logic [32:0] div_diff;
  logic [63:0] div_next;
  assign div_diff = acc[63:31] - {1'b0, opnd};
  assign div_next = div_diff[32] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};

  // Sign correction applied in FIX. The most negative quotient wraps onto itself.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_hi, fix_lo;
  assign prod_fix = neg_res ? (64'd0 - acc) : acc;
  assign quo_fix  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
  assign rem_fix  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
  assign fix_hi   = is_div ? rem_fix : prod_fix[63:32];
  assign fix_lo   = is_div ? quo_fix : prod_fix[31:0];

  assign Busy = (state == RUN) || (state == FIX);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      acc       <= 64'd0;
      opnd      <= 32'd0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      dbz_pend  <= 1'b0;
      Hi        <= 32'd0;
      Lo        <= 32'd0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && !Flush) begin
            case (Op)
              OP_MTHI: Hi <= A;
              OP_MTLO: Lo <= A;
              OP_MULT, OP_MULTU: begin
                acc      <= {32'd0, b_mag};
                opnd     <= a_mag;
                is_div   <= 1'b0;
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= 1'b0;
                dbz_pend <= 1'b0;
                cnt      <= 5'd31;
                state    <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                is_div <= 1'b1;
                if (B == 32'd0) begin
                  dbz_pend <= 1'b1;
                  state    <= FIX;
                end else begin
                  acc      <= {32'd0, a_mag};
                  opnd     <= b_mag;
                  neg_res  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  dbz_pend <= 1'b0;
                  cnt      <= 5'd31;
                  state    <= RUN;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (Flush) begin
            state <= IDLE;
          end else begin
            acc <= is_div ? div_next : mul_next;
            if (cnt == 5'd0) state <= FIX;
            else             cnt   <= cnt - 5'd1;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!Flush) begin
            Done <= 1'b1;
            if (dbz_pend) begin
              DivByZero <= 1'b1;
            end else begin
              Hi <= fix_hi;
              Lo <= fix_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed scoreboard bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Rst, Start, Flush;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;

  ex_muldiv_unit dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns one negedge later (inside the first busy cycle).
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, q, r;
    logic [63:0] p;
    e.hi = m_hi; e.lo = m_lo; e.dbz = 1'b0; e.lat = 33;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd2: if (b == 0) begin e.dbz = 1'b1; e.lat = 1; end
            else begin q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0]; end
      default: if (b == 0) begin e.dbz = 1'b1; e.lat = 1; end
               else begin e.lo = a / b; e.hi = a % b; end
    endcase
    m_hi = e.hi; m_lo = e.lo;
    sb.push_back(e);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done;
    int   busy_n = 0;
    int   cyc = 0;
    exp_t e;
    while (Done !== 1'b1 && cyc < 100) begin
      if (Busy === 1'b1) busy_n++;
      cyc++;
      @(negedge Clk);
    end
    e = sb.pop_front();
    check("done_seen", {63'd0, Done}, 64'd1);
    check("busy_cycles", 64'(busy_n), 64'(e.lat));
    check("busy_at_done", {63'd0, Busy}, 64'd0);
    check("hi", {32'd0, Hi}, {32'd0, e.hi});
    check("lo", {32'd0, Lo}, {32'd0, e.lo});
    check("divbyzero", {63'd0, DivByZero}, {63'd0, e.dbz});
  endtask

  task automatic move(input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1; Op = op; A = a;
    @(negedge Clk);
    Start = 1'b0;
    if (op == 3'd4) m_hi = a; else m_lo = a;
    check("move_hi", {32'd0, Hi}, {32'd0, m_hi});
    check("move_lo", {32'd0, Lo}, {32'd0, m_lo});
    check("move_busy", {63'd0, Busy}, 64'd0);
    @(negedge Clk);
    check("move_no_done", {62'd0, Done, Busy}, 64'd0);
  endtask

  initial begin
    int dn;
    Rst = 1'b1; Start = 1'b0; Flush = 1'b0; Op = 3'd0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge Clk);
    check("rst_outs", {Hi, Lo}, 64'd0);
    check("rst_flags", {61'd0, Busy, Done, DivByZero}, 64'd0);
    Rst = 1'b0;
    @(negedge Clk);

    start_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done();
    check("multu_max", {Hi, Lo}, 64'hFFFFFFFE_00000001);
    // Back-to-back start in the Done cycle
    start_op(3'd0, 32'hFFFFFFFD, 32'h00000007);
    check("done_single", {63'd0, Done}, 64'd0);
    wait_done();
    check("mult_neg", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFEB);
    start_op(3'd2, 32'hFFFFFFF9, 32'h00000002);
    wait_done();
    check("div_neg", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);
    start_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done();
    check("div_wrap", {Hi, Lo}, 64'h00000000_80000000);
    start_op(3'd2, 32'h00000007, 32'hFFFFFFFE);
    wait_done();
    start_op(3'd0, 32'h80000000, 32'h80000000);
    wait_done();
    start_op(3'd3, 32'hFFFFFFFF, 32'h00000010);
    wait_done();
    start_op(3'd1, 32'h0001E240, 32'h00BC614E);
    wait_done();

    move(3'd4, 32'h00000011);
    move(3'd5, 32'h00000022);
    start_op(3'd3, 32'h00000064, 32'h00000000);
    wait_done();
    check("dbz_keep", {Hi, Lo}, 64'h00000011_00000022);

    // Reserved opcode is ignored
    Start = 1'b1; Op = 3'd6; A = 32'hAAAA5555;
    @(negedge Clk);
    Start = 1'b0;
    check("rsvd_busy", {63'd0, Busy}, 64'd0);
    @(negedge Clk);
    check("rsvd_done", {63'd0, Done}, 64'd0);
    check("rsvd_hilo", {Hi, Lo}, {m_hi, m_lo});

    // Flush wins over Start in IDLE
    Start = 1'b1; Flush = 1'b1; Op = 3'd4; A = 32'hDEADBEEF;
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    check("flush_start_hi", {32'd0, Hi}, {32'd0, m_hi});
    check("flush_start_busy", {63'd0, Busy}, 64'd0);

    // MULT, re-Start at RUN cycle 5, Flush at RUN cycle 10
    Start = 1'b1; Op = 3'd0; A = 32'd5; B = 32'd6;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Start = 1'b1; Op = 3'd5; A = 32'h00000BAD;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    check("flush_run_busy", {63'd0, Busy}, 64'd0);
    dn = 0;
    repeat (40) begin
      if (Done === 1'b1) dn++;
      @(negedge Clk);
    end
    check("flush_run_no_done", 64'(dn), 64'd0);
    check("flush_run_hilo", {Hi, Lo}, {m_hi, m_lo});

    // Flush while in FIX of a divide-by-zero
    Start = 1'b1; Op = 3'd3; A = 32'd9; B = 32'd0;
    @(negedge Clk);
    Start = 1'b0;
    check("dbz_fix_busy", {63'd0, Busy}, 64'd1);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    check("flush_fix", {61'd0, Busy, Done, DivByZero}, 64'd0);

    // Reset mid-RUN
    move(3'd4, 32'h12345678);
    Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (19) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check("rst_run_hilo", {Hi, Lo}, 64'd0);
    check("rst_run_flags", {61'd0, Busy, Done, DivByZero}, 64'd0);
    dn = 0;
    repeat (20) begin
      if (Done === 1'b1 || Busy === 1'b1) dn++;
      @(negedge Clk);
    end
    check("rst_run_quiet", 64'(dn), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have port Clk, input, 1, clock; all state changes on rising edge.
REQ-002 SHALL have port Rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port Start, input, 1, operation request from ID/EX register output.
REQ-004 SHALL have port Op, input, 3, operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-005 SHALL have port A, input, 32, operand from Rs (dividend/multiplicand/move source).
REQ-006 SHALL have port B, input, 32, operand from Rt (divisor/multiplier).
REQ-007 SHALL have port Flush, input, 1, abort request from branch/jump resolution.
REQ-008 SHALL have port Busy, output, 1, stall request to hazard logic.
REQ-009 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port DivByZero, output, 1, one-cycle pulse coincident with Done for DIV/DIVU with B=0.
REQ-011 SHALL have ports Hi and Lo, output, 32 each, architectural HI/LO registers.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX; Busy=1 exactly when state is RUN or FIX.
REQ-013 SHALL accept Start only in IDLE with Flush=0; Start while Busy=1 SHALL be ignored.
REQ-014 SHALL ignore reserved Op codes: no state change, Busy stays 0, no Done.
REQ-015 SHALL, for MTHI/MTLO accepted at edge E, write A to Hi/Lo at E; Busy never asserts; no Done.
REQ-016 SHALL, for MULT/MULTU/DIV/DIVU with nonzero divisor, latch operand magnitudes at acceptance edge, enter RUN with 5-bit iteration counter = 31.
REQ-017 SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per RUN cycle; counter decrements; RUN->FIX when counter = 0 after its step (32 RUN cycles).
REQ-018 SHALL, in FIX, apply sign correction and at FIX's closing edge write Hi/Lo, return to IDLE, set Done=1 for the next cycle.
REQ-019 Latency: Busy high for exactly 33 cycles after acceptance edge; new Hi/Lo and Done visible in the 34th cycle; a new Start is accepted in that same Done cycle.
REQ-020 MULT SHALL produce the signed 64-bit product; MULTU unsigned; Hi = bits 63:32, Lo = bits 31:0.
REQ-021 DIV/DIVU SHALL put quotient in Lo, remainder in Hi; DIV truncates toward zero, quotient negative iff operand signs differ, remainder takes sign of A.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0x00000000 (wrap, no flag).
REQ-023 DIV/DIVU with B=0 SHALL go IDLE->FIX (Busy 1 cycle), leave Hi/Lo unchanged, pulse Done and DivByZero together.
REQ-024 Flush=1 in RUN or FIX SHALL return state to IDLE at that edge, Hi/Lo unchanged, no Done; Flush with Start in IDLE: Flush wins, Start ignored.
REQ-025 Flush SHALL NOT cancel a Done/DivByZero pulse already being driven.
REQ-026 Done and DivByZero SHALL be registered, never high for more than one consecutive cycle per operation.

Reset
REQ-027 Rst=1 at an edge SHALL set state IDLE, counter 0, Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, clearing internal operand/accumulator registers.
REQ-028 Rst SHALL take priority over Start, Flush and any in-progress operation, including mid-RUN or FIX.

Verification
REQ-029 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Busy 33 cycles, then Hi=0xFFFFFFFE, Lo=0x00000001, Done 1 cycle.
REQ-030 MULT A=0xFFFFFFFD B=0x00000007 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DIV A=0xFFFFFFF9 B=0x00000002 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-031 DIV A=0x80000000 B=0xFFFFFFFF -> Lo=0x80000000, Hi=0x00000000, DivByZero=0.
REQ-032 DIVU A=0x00000064 B=0 with prior Hi=0x11, Lo=0x22 -> Busy 1 cycle, Done=DivByZero=1, Hi=0x11, Lo=0x22.
REQ-033 MULT started, Start re-pulsed at RUN cycle 5, Flush at RUN cycle 10 -> Busy low next cycle, no Done, Hi/Lo unchanged, second Start never executed.
REQ-034 MTHI A=0x12345678 -> Hi=0x12345678 next cycle, Busy never high; then DIVU started, Rst at RUN cycle 20 -> all outputs 0 next cycle.
